// File: rtl/tt_vpu_ovi_issue_ctrl.sv
// tt_vpu_ovi_issue_ctrl: OVI vector issue queue with sb_id resolution, in-order release and credit return
module tt_vpu_ovi_issue_ctrl #(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             issue_valid,
  input  logic [31:0]      issue_inst,
  input  logic [4:0]       issue_sb_id,
  input  logic [63:0]      issue_scalar_opnd,
  input  logic [39:0]      issue_vcsr,
  input  logic             issue_vcsr_lmulb2,
  output logic             issue_credit,
  input  logic [4:0]       dispatch_sb_id,
  input  logic             dispatch_next_senior,
  input  logic             dispatch_kill,
  output logic             exec_valid,
  input  logic             exec_ready,
  output logic [31:0]      exec_inst,
  output logic [4:0]       exec_sb_id,
  output logic [63:0]      exec_scalar_opnd,
  output logic [40:0]      exec_vcsr,
  output logic [CNT_W-1:0] occupancy,
  output logic             protocol_err
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [1:0] PEND = 2'd0;
  localparam logic [1:0] SENIOR = 2'd1;
  localparam logic [1:0] KILLED = 2'd2;

  logic [31:0]      inst_q [DEPTH];
  logic [31:0]      inst_d [DEPTH];
  logic [4:0]       sb_q [DEPTH];
  logic [4:0]       sb_d [DEPTH];
  logic [63:0]      opnd_q [DEPTH];
  logic [63:0]      opnd_d [DEPTH];
  logic [40:0]      vcsr_q [DEPTH];
  logic [40:0]      vcsr_d [DEPTH];
  logic [1:0]       st_q [DEPTH];
  logic [1:0]       st_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [DEPTH-1:0] hit, dup;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] occ_q, occ_d, cnt_q, cnt_d;
  logic             credit_q, credit_d, err_q, err_d;
  logic             disp_any, disp_both, issue_err, issue_ok, same_sb, disp_err, disp_ok, pop;
  logic [1:0]       hd_st, init_st;

  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return p == PTR_W'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  for (genvar g = 0; g < DEPTH; g++) begin : g_cam
    assign hit[g] = vld_q[g] && st_q[g] == PEND && sb_q[g] == dispatch_sb_id;
    assign dup[g] = vld_q[g] && sb_q[g] == issue_sb_id;
  end

  assign hd_st            = st_q[head_q];
  assign exec_valid       = vld_q[head_q] && hd_st == SENIOR;
  assign pop              = vld_q[head_q] && (hd_st == KILLED || (hd_st == SENIOR && exec_ready));
  assign disp_any         = dispatch_next_senior | dispatch_kill;
  assign disp_both        = dispatch_next_senior & dispatch_kill;
  assign issue_err        = issue_valid && (occ_q == CNT_W'(DEPTH) || |dup);
  assign issue_ok         = issue_valid && !issue_err;
  assign same_sb          = issue_ok && dispatch_sb_id == issue_sb_id;
  assign disp_err         = disp_both || (disp_any && !(|hit) && !same_sb);
  assign disp_ok          = disp_any && !disp_err;
  assign init_st          = disp_ok && same_sb ? (dispatch_kill ? KILLED : SENIOR) : PEND;
  assign exec_inst        = inst_q[head_q];
  assign exec_sb_id       = sb_q[head_q];
  assign exec_scalar_opnd = opnd_q[head_q];
  assign exec_vcsr        = vcsr_q[head_q];
  assign occupancy        = occ_q;
  assign issue_credit     = credit_q;
  assign protocol_err     = err_q;

  // Next state: resolve dispatches, retire the head, append the new issue, track credits
  always_comb begin
    inst_d = inst_q;
    sb_d = sb_q;
    opnd_d = opnd_q;
    vcsr_d = vcsr_q;
    st_d = st_q;
    vld_d = vld_q;
    for (int i = 0; i < DEPTH; i++)
      if (disp_ok && hit[i]) st_d[i] = dispatch_kill ? KILLED : SENIOR;
    if (pop) vld_d[head_q] = 1'b0;
    if (issue_ok) begin
      vld_d[tail_q] = 1'b1;
      st_d[tail_q] = init_st;
      inst_d[tail_q] = issue_inst;
      sb_d[tail_q] = issue_sb_id;
      opnd_d[tail_q] = issue_scalar_opnd;
      vcsr_d[tail_q] = {issue_vcsr_lmulb2, issue_vcsr};
    end
    head_d = pop ? nxt(head_q) : head_q;
    tail_d = issue_ok ? nxt(tail_q) : tail_q;
    occ_d = occ_q + CNT_W'(issue_ok) - CNT_W'(pop);
    cnt_d = cnt_q + CNT_W'(pop) - CNT_W'(cnt_q != '0);
    credit_d = cnt_q != '0;
    err_d = err_q | issue_err | disp_err;
  end

  // Control state; reset drops every entry and restarts the full credit grant
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      occ_q <= '0;
      cnt_q <= CNT_W'(DEPTH);
      credit_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q <= occ_d;
      cnt_q <= cnt_d;
      credit_q <= credit_d;
      err_q <= err_d;
    end
  end

  // Entry payload and state; meaningful only where the entry's valid bit is set
  always_ff @(posedge clk) begin
    inst_q <= inst_d;
    sb_q <= sb_d;
    opnd_q <= opnd_d;
    vcsr_q <= vcsr_d;
    st_q <= st_d;
  end
endmodule
